// File: rtl/gpmc_pwm_bank.sv
// GPMC-mapped PWM bank: double-buffered period/duty registers that load at each period wrap.
// Read data appears one clk after the strobe and pwm_out one clk after cnt; no backpressure (strobes are level-based).
module gpmc_pwm_bank #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [NUM_CH-1:0]     pwm_out,
  output logic                  period_tick
);

  localparam logic [ADDR_WIDTH-1:0] A_CTRL     = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] A_PRESCALE = ADDR_WIDTH'(8'h01);
  localparam logic [ADDR_WIDTH-1:0] A_PERIOD   = ADDR_WIDTH'(8'h02);
  localparam logic [ADDR_WIDTH-1:0] A_COUNT    = ADDR_WIDTH'(8'h10);
  localparam logic [ADDR_WIDTH-1:0] A_WRAPS    = ADDR_WIDTH'(8'h11);
  localparam logic [ADDR_WIDTH-1:0] A_ID       = ADDR_WIDTH'(8'h1F);
  localparam int                    DUTY_BASE  = 3;
  localparam logic [DATA_WIDTH-1:0] ID_VAL     = DATA_WIDTH'(16'hB3E0);

  logic [1:0]            ctrl;
  logic [DATA_WIDTH-1:0] prescale;
  logic [DATA_WIDTH-1:0] period;
  logic [DATA_WIDTH-1:0] duty [NUM_CH];
  logic [DATA_WIDTH-1:0] active_period;
  logic [DATA_WIDTH-1:0] active_duty [NUM_CH];
  logic [DATA_WIDTH-1:0] pre;
  logic [DATA_WIDTH-1:0] cnt;
  logic [15:0]           wraps;
  logic [DATA_WIDTH-1:0] rd_dat;

  logic wr, rd, en, inv, en_rise, tick, wrap;

  assign wr   = !cs && !we && oe;
  assign rd   = !cs && we && !oe;
  assign en   = ctrl[0];
  assign inv  = ctrl[1];
  assign tick = (pre == prescale);
  assign wrap = tick && (cnt == active_period);
  // Enabling restarts the period from a clean boundary with fresh shadows.
  assign en_rise = wr && (address == A_CTRL) && data_out[0] && !ctrl[0];

  always_comb begin
    rd_dat = '0;
    if (address == A_CTRL)     rd_dat = DATA_WIDTH'(ctrl);
    if (address == A_PRESCALE) rd_dat = prescale;
    if (address == A_PERIOD)   rd_dat = period;
    if (address == A_COUNT)    rd_dat = cnt;
    if (address == A_WRAPS)    rd_dat = DATA_WIDTH'(wraps);
    if (address == A_ID)       rd_dat = ID_VAL;
    for (int n = 0; n < NUM_CH; n++) begin
      if (address == ADDR_WIDTH'(DUTY_BASE + n)) rd_dat = duty[n];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl     <= '0;
      prescale <= '0;
      period   <= '0;
      for (int n = 0; n < NUM_CH; n++) duty[n] <= '0;
    end else if (wr) begin
      if (address == A_CTRL)     ctrl     <= data_out[1:0];
      if (address == A_PRESCALE) prescale <= data_out;
      if (address == A_PERIOD)   period   <= data_out;
      for (int n = 0; n < NUM_CH; n++) begin
        if (address == ADDR_WIDTH'(DUTY_BASE + n)) duty[n] <= data_out;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_in <= '0;
    else        data_in <= rd ? rd_dat : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre           <= '0;
      cnt           <= '0;
      wraps         <= '0;
      period_tick   <= 1'b0;
      active_period <= '0;
      for (int n = 0; n < NUM_CH; n++) active_duty[n] <= '0;
    end else begin
      period_tick <= 1'b0;
      if (en_rise) begin
        pre           <= '0;
        cnt           <= '0;
        active_period <= period;
        active_duty   <= duty;
      end else if (!en) begin
        pre <= '0;
        cnt <= '0;
      end else if (tick) begin
        pre <= '0;
        if (wrap) begin
          cnt           <= '0;
          period_tick   <= 1'b1;
          wraps         <= wraps + 16'd1;
          active_period <= period;
          active_duty   <= duty;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        pwm_out[n] <= en ? ((cnt < active_duty[n]) ^ inv) : 1'b0;
      end
    end
  end

endmodule

// File: doc/gpmc_pwm_bank.md
Name: gpmc_pwm_bank

Overview:
Memory-mapped PWM register bank that sits directly downstream of the GPMC synchronous controller (gpmc_sync). It consumes that controller's cs/we/oe/address/data_out strobes, returns read data on data_in, and drives NUM_CH PWM outputs (LEDs/PMOD pins). Duty and period are double-buffered: new values load only at a period boundary, so there are no glitches.

Parameters:
ADDR_WIDTH, 5, word address width (matches gpmc_sync).
DATA_WIDTH, 16, register and data bus width.
NUM_CH, 4, number of PWM channels (1..12).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cs  input  1  chip select from gpmc_sync, active-low
we  input  1  write enable from gpmc_sync, active-low
oe  input  1  output enable from gpmc_sync, active-low
address  input  ADDR_WIDTH  word address
data_out  input  DATA_WIDTH  write data (ARM -> FPGA)
data_in  output  DATA_WIDTH  read data (FPGA -> ARM)
pwm_out  output  NUM_CH  PWM outputs
period_tick  output  1  one-clk pulse at each period wrap

Behaviour:
- Reset (async on rst_n low, released sync to clk): all registers 0; data_in=0, pwm_out=0, period_tick=0; prescaler and counter 0.
- Write: on a clk edge with cs=0, we=0, oe=1, register[address] <= data_out. Level-based: repeated cycles rewrite the same value. Writes to read-only or unmapped addresses are ignored.
- Read: on a clk edge with cs=0, we=1, oe=0, data_in <= register[address] (1-cycle latency). Otherwise data_in <= 0. Unmapped addresses read 0.
- Register map (word addresses):
  - 0x00 CTRL, RW: bit0 EN, bit1 INV; other bits read 0.
  - 0x01 PRESCALE, RW.
  - 0x02 PERIOD, RW (pending).
  - 0x03..0x03+NUM_CH-1 DUTY[n], RW (pending).
  - 0x10 COUNT, RO: active counter value.
  - 0x11 WRAPS, RO: period-wrap count, 16-bit, wraps 0xFFFF->0.
  - 0x1F ID, RO: constant 0xB3E0.
- Reads of PERIOD/DUTY return the pending (last written) value.
- Prescaler: pre counts 0..PRESCALE. tick=1 when pre==PRESCALE, then pre<=0. PRESCALE=0 gives a tick every clk.
- Counter: on tick, if cnt==active_period then cnt<=0 and wrap=1, else cnt<=cnt+1.
  - Period length = active_period+1 ticks.
  - active_period=0: wrap on every tick.
- Shadow load:
  - On a wrap, active_period <= PERIOD and active_duty[n] <= DUTY[n] (register values before that edge).
  - A write in the same cycle as a wrap takes effect at the next wrap.
  - Also load when EN goes 0->1, with cnt=0 and pre=0.
- Output: pwm_out[n] = EN ? ((cnt < active_duty[n]) ^ INV) : 0, registered (one clk after cnt).
  - duty=0: constant 0.
  - duty>=active_period+1: constant 1 (before INV).
  - Comparison is unsigned, full DATA_WIDTH.
- EN=0: pre, cnt, period_tick held at 0; WRAPS holds its value.
- period_tick: 1-clk pulse, registered, coincident with the wrap edge. WRAPS increments on the same wrap.
- Simultaneous read and write cannot occur (we/oe exclusive). If both we=0 and oe=0, do nothing.
- Reset mid-period: outputs drop to 0 immediately (async); all registers return to their reset values.

Test Plan:
- Reset, then read ID (0x1F) -> data_in=0xB3E0 one clk after the read strobe; read 0x05 with NUM_CH=4 -> 0x0000.
- PRESCALE=0, PERIOD=9, DUTY0=3, CTRL=1 -> pwm_out[0] high 3 of every 10 clks; period_tick every 10 clks; WRAPS=5 after 50 clks.
- Duty edges: DUTY1=0 -> constant 0; DUTY2=10 with PERIOD=9 -> constant 1; CTRL=3 (INV) -> both outputs inverted.
- Write DUTY0=7 mid-period (cnt=4) -> waveform unchanged until the next wrap, then 7/10; readback of 0x03 returns 7 immediately.
- PRESCALE=2, PERIOD=1 -> period_tick every 6 clks; COUNT reads alternate 0/1 per 3 clks.
- Assert rst_n low mid-period -> pwm_out=0 and data_in=0 without waiting for a clk edge; after release, CTRL reads 0 and the outputs stay low.
